// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the parity-mode and TX FSM state types, the default bit-period
// length, and small helpers for frame length and parity generation.
package uart_pkg;

    // Existing team encoding: ODD = 0, EVEN = 1.
    typedef enum logic {
        ODD  = 1'b0,
        EVEN = 1'b1
    } parity_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_e;

    localparam int unsigned UART_CLK_DIV_DEFAULT = 16;
    localparam int unsigned UART_DATA_BITS       = 8;

    // Frame length in bit periods: start + data + optional parity + stop.
    function automatic int unsigned frame_bits(input logic parity_en,
                                               input int unsigned stop_bits);
        return 1 + UART_DATA_BITS + (parity_en ? 1 : 0) + stop_bits;
    endfunction

    // ODD makes data+parity carry an odd number of ones; EVEN an even one.
    function automatic logic parityGen(input logic [7:0] data, input parity_mode_e mode);
        return (mode == EVEN) ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter shared by the UART TX and RX paths.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_clear     - synchronous clear, restarts a bit period at count 0
//   o_bit_tick  - high for the last cycle of each CLK_DIV-cycle bit period
module uart_baud_gen #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_bit_tick
);

    localparam logic [15:0] CntLast = 16'(CLK_DIV - 1);

    logic [15:0] r_cnt;

    assign o_bit_tick = (r_cnt == CntLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || o_bit_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 8 data bits LSB-first, optional
// parity bit, STOP_BITS stop bits, each held for CLK_DIV clocks.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   tx_data, tx_valid     - byte to send and its valid
//   tx_ready              - high in IDLE; a byte is taken on valid && ready
//   parity_en, parity_mode- parity insert enable and ODD/EVEN select
//   tx                    - registered serial line, idles high
//   busy                  - a frame is in progress
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = UART_CLK_DIV_DEFAULT,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    input  logic         parity_en,
    input  parity_mode_e parity_mode,
    output logic         tx,
    output logic         busy
);

    localparam logic [2:0] BitIdxLast = 3'(UART_DATA_BITS - 1);
    localparam logic       StopLast   = (STOP_BITS == 2);

    uart_tx_state_e r_state, w_state_d;
    logic [7:0]     r_shift, w_shift_d;
    logic [2:0]     r_bit_idx, w_bit_idx_d;
    logic           r_stop_cnt, w_stop_cnt_d;
    logic           r_tx, w_tx_d;
    logic           r_parity_en;
    logic           r_parity_bit;
    logic           w_handshake;
    logic           w_bit_tick;

    assign tx_ready    = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign tx          = r_tx;
    assign w_handshake = tx_valid && tx_ready;

    uart_baud_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_baud_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_handshake),
        .o_bit_tick(w_bit_tick)
    );

    // Next state and the next value of the registered line, so tx changes
    // on the same edge as the state it belongs to.
    always_comb begin
        w_state_d    = r_state;
        w_shift_d    = r_shift;
        w_bit_idx_d  = r_bit_idx;
        w_stop_cnt_d = r_stop_cnt;
        w_tx_d       = r_tx;
        unique case (r_state)
            ST_IDLE: begin
                w_tx_d = 1'b1;
                if (tx_valid) begin
                    w_state_d    = ST_START;
                    w_shift_d    = tx_data;
                    w_bit_idx_d  = '0;
                    w_stop_cnt_d = 1'b0;
                    w_tx_d       = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_tick) begin
                    w_state_d = ST_DATA;
                    w_tx_d    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_tick) begin
                    w_shift_d   = r_shift >> 1;
                    w_bit_idx_d = r_bit_idx + 3'd1;
                    if (r_bit_idx == BitIdxLast) begin
                        if (r_parity_en) begin
                            w_state_d = ST_PARITY;
                            w_tx_d    = r_parity_bit;
                        end else begin
                            w_state_d = ST_STOP;
                            w_tx_d    = 1'b1;
                        end
                    end else begin
                        w_tx_d = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_tick) begin
                    w_state_d = ST_STOP;
                    w_tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                w_tx_d = 1'b1;
                if (w_bit_tick) begin
                    if (r_stop_cnt == StopLast) begin
                        w_state_d = ST_IDLE;
                    end else begin
                        w_stop_cnt_d = r_stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_shift    <= w_shift_d;
            r_bit_idx  <= w_bit_idx_d;
            r_stop_cnt <= w_stop_cnt_d;
            r_tx       <= w_tx_d;
        end
    end

    // Parity is fixed at capture time so later input changes cannot alter it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_en  <= 1'b0;
            r_parity_bit <= 1'b0;
        end else if (w_handshake) begin
            r_parity_en  <= parity_en;
            r_parity_bit <= parityGen(tx_data, parity_mode);
        end
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmit serializer producing 8N1/8E1/8O1/8x2 frames on a single serial line. It accepts one byte per valid/ready handshake, generates the parity bit, and shifts the frame out LSB-first at a fixed clocks-per-bit rate. It sits directly upstream of the UART receive/parity-check path and drives the serial wire that the receiver and the DV parity checker consume.

## Interface
- `CLK_DIV`, 16: clocks per bit period; legal range 2..65535.
- `STOP_BITS`, 1: number of stop bits; 1 or 2.
- `clk` input 1: sole clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `tx_data` input 8: byte to send.
- `tx_valid` input 1: `tx_data` and the configuration inputs are valid.
- `tx_ready` output 1: block can accept a byte this cycle.
- `parity_en` input 1: 1 inserts a parity bit after the data bits.
- `parity_mode` input 1: 0 = ODD, 1 = EVEN; same encoding as `parity_mode_e`.
- `tx` output 1: serial line; idles high.
- `busy` output 1: a frame is in progress.

## Operation
- States are IDLE, START, DATA, PARITY and STOP.
  - IDLE -> START on handshake.
  - START -> DATA after 1 bit period.
  - DATA -> PARITY after 8 bits if `parity_en`, otherwise DATA -> STOP.
  - PARITY -> STOP after 1 bit period.
  - STOP -> IDLE after `STOP_BITS` bit periods.
- Handshake: a transfer occurs when `tx_valid && tx_ready`.
  - `tx_ready` = (state == IDLE), decoded combinationally from state.
  - `tx_valid` is ignored while `tx_ready` = 0; the upstream holds data until accepted.
- On handshake, capture `tx_data` into an 8-bit shift register, and capture `parity_en` and `parity_mode`. Changes to these inputs mid-frame have no effect.
- Parity bit:
  - ODD: `~^data`, so the total count of ones in data plus parity is odd.
  - EVEN: `^data`.
  - It is computed from the captured byte.
- Bit timing: a baud counter runs 0..`CLK_DIV`-1 and wraps. A bit period ends when the counter reaches `CLK_DIV`-1. The counter is cleared on handshake.
- Data order: LSB first. `bit_idx` is a 3-bit counter from 0 to 7, and the shift register shifts right at each DATA bit-period end.
- `tx` drives 0 in START, `shift[0]` in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
- `busy` = (state != IDLE).

## Timing
- Reset values: `tx` = 1, `busy` = 0, `tx_ready` = 1, state = IDLE, all counters 0.
- `tx` is registered. For a handshake in cycle N, `tx` falls in cycle N+1.
- Each bit holds for exactly `CLK_DIV` cycles.
- Frame duration is (1 + 8 + `parity_en` + `STOP_BITS`) × `CLK_DIV` cycles, counted from cycle N+1.
- After the last stop period the FSM spends exactly 1 cycle in IDLE with `tx` = 1 and `tx_ready` = 1.
  - The earliest next start bit is therefore one cycle later, so the effective stop length is `STOP_BITS` × `CLK_DIV` + 1 cycles under back-to-back traffic.
- Reset mid-frame: `tx` goes to 1 and `busy` to 0 asynchronously. The partial frame is discarded and never resumed.
- `tx_valid` asserted during reset is not accepted. The first handshake can occur in the first clock edge after `rst_n` deasserts.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum `uart_tx_state_e`;
  - the `CLK_DIV` default;
  - the frame-length helper constant.
- `parity_mode` is typed as the team's existing `parity_mode_e` (ODD = 0, EVEN = 1). The TB scoreboard reuses its `parityGen` reference function.
- Sub-module `uart_baud_gen` contains the `CLK_DIV` counter with a sync clear. It outputs a one-cycle `bit_tick` pulse and is reused later by the RX path.
- Expected size: ~150–250 lines RTL including the sub-module.

## Test plan
- Byte 8'hA5 with `CLK_DIV` = 4, `parity_en` = 1, EVEN:
  - `tx` sequence is 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1, each held 4 cycles.
  - Start bit begins at handshake+1.
  - `tx_ready` returns high after 44 cycles.
- Same byte with ODD parity: the parity bit is 1, and everything else is identical.
- Byte 8'h00 with `parity_en` = 0 and `STOP_BITS` = 2:
  - Frame is 11 bits, 44 cycles at `CLK_DIV` = 4.
  - No parity slot; stop is high for 8 cycles.
- Back-to-back: `tx_valid` held high with 8'h55 then 8'hAA.
  - The second start bit falls exactly 1 cycle after the first frame's stop period ends.
  - `tx_valid` is ignored while `busy` = 1.
- Change `parity_mode` and `tx_data` mid-frame: the frame is unaffected, and the parity still matches the byte captured at handshake.
- Assert `rst_n` = 0 during DATA bit 3:
  - `tx` = 1 and `busy` = 0 immediately.
  - After release, a new 8'h3C frame transmits correctly from its start bit.
